// File: rtl/exu_pkg.sv
// Shared encodings for the execute pipe: ALU opcodes, next-PC codes,
// controller state and the branch-condition helper.
package exu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLT  = 4'd2;
  localparam logic [3:0] OP_SLTU = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_MUL  = 4'd8;

  localparam logic [2:0] BR_JAL  = 3'b001;
  localparam logic [2:0] BR_JALR = 3'b010;
  localparam logic [2:0] BR_BEQ  = 3'b100;
  localparam logic [2:0] BR_BNE  = 3'b101;
  localparam logic [2:0] BR_BLT  = 3'b110;
  localparam logic [2:0] BR_BGE  = 3'b111;

  // state   | meaning
  // ST_IDLE | ready to issue, latency-1 ops complete here
  // ST_MUL  | iterative multiply in progress, issue blocked
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  // Taken decision for the conditional codes; jal/jalr/sequential are
  // resolved directly by the caller, so they report not-taken here.
  function automatic logic br_taken(input logic [2:0] br, input logic zero,
                                    input logic lt);
    case (br)
      BR_BEQ:  return zero;
      BR_BNE:  return !zero;
      BR_BLT:  return lt;
      BR_BGE:  return zero || !lt;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/exu_mul_iter.sv
// Iterative shift-add multiplier retiring MUL_STEP multiplier bits per cycle.
// The first step is taken on the start cycle, so done rises after
// XLEN/MUL_STEP steps and product holds the low XLEN bits of opa*opb.
module exu_mul_iter
#(
  parameter int XLEN     = 64,
  parameter int MUL_STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            abort,
  input  logic            start,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  output logic            done,
  output logic [XLEN-1:0] product
);

  localparam int STEPS = XLEN / MUL_STEP;
  localparam int CW    = $clog2(STEPS + 1);

  logic [XLEN-1:0] mcand, mplier, acc;
  logic [XLEN-1:0] mcand_in, mplier_in, acc_in, acc_nxt;
  logic [CW-1:0]   cnt;
  logic            busy;

  // partial-product accumulate for the current step (fresh operands on start)
  always_comb begin
    mcand_in  = start ? opa : mcand;
    mplier_in = start ? opb : mplier;
    acc_in    = start ? '0 : acc;
    acc_nxt   = acc_in;
    for (int i = 0; i < MUL_STEP; i++) begin
      if (mplier_in[i]) acc_nxt = acc_nxt + (mcand_in << i);
    end
  end

  // step sequencing; abort drops the operation without raising done
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      busy   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= CW'(1);
      acc    <= acc_nxt;
      mcand  <= opa << MUL_STEP;
      mplier <= opb >> MUL_STEP;
    end else if (busy && cnt != CW'(STEPS)) begin
      cnt    <= cnt + CW'(1);
      acc    <= acc_nxt;
      mcand  <= mcand << MUL_STEP;
      mplier <= mplier >> MUL_STEP;
    end else if (done) begin
      busy <= 1'b0;
      cnt  <= '0;
    end
  end

  assign done    = busy && (cnt == CW'(STEPS));
  assign product = acc;

endmodule

// File: rtl/exu_pipe.sv
// Execute pipe: single-cycle ALU plus next-PC select with a registered
// result handshake. Optional iterative multiplier enabled by the macro
// EXU_PIPE_MUL_EN; without it MUL completes in one cycle flagged illegal.
module exu_pipe
  import exu_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int MUL_STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] srca,
  input  logic [XLEN-1:0] srcb,
  input  logic [3:0]      alu_op,
  input  logic [2:0]      branch,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] busa,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_res,
  output logic [XLEN-1:0] out_dnpc,
  output logic            out_illegal,
  input  logic            flush
);

  if ((XLEN != 32 && XLEN != 64) ||
      (MUL_STEP != 1 && MUL_STEP != 2 && MUL_STEP != 4) ||
      (XLEN % MUL_STEP) != 0) begin : g_bad_cfg
    $error("exu_pipe: unsupported XLEN/MUL_STEP combination");
  end

  logic            idle, accept, load_alu;
  logic [XLEN-1:0] alu_res;
  logic            alu_ill;

  // next PC; zero/lt come from the result of the op that carried the branch
  function automatic logic [XLEN-1:0] next_pc(input logic [2:0]      br,
                                              input logic [XLEN-1:0] pc_v,
                                              input logic [XLEN-1:0] imm_v,
                                              input logic [XLEN-1:0] busa_v,
                                              input logic [XLEN-1:0] res_v);
    logic [XLEN-1:0] npc;
    logic            zero, lt;
    zero = (res_v == '0);
    lt   = res_v[0];
    case (br)
      BR_JAL:  npc = pc_v + imm_v;
      BR_JALR: npc = busa_v + imm_v;
      BR_BEQ, BR_BNE, BR_BLT, BR_BGE:
        npc = br_taken(br, zero, lt) ? pc_v + imm_v : pc_v + XLEN'(4);
      default: npc = pc_v + XLEN'(4);
    endcase
    npc[0] = 1'b0;
    return npc;
  endfunction

  // single-cycle ALU; unsupported opcodes flag illegal with a zero result
  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (alu_op)
      OP_ADD:  alu_res = srca + srcb;
      OP_SUB:  alu_res = srca - srcb;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(srca) < $signed(srcb)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, srca < srcb};
      OP_AND:  alu_res = srca & srcb;
      OP_OR:   alu_res = srca | srcb;
      OP_XOR:  alu_res = srca ^ srcb;
`ifdef EXU_PIPE_MUL_EN
      OP_MUL:  alu_ill = 1'b0;
`endif
      default: alu_ill = 1'b1;
    endcase
  end

`ifdef EXU_PIPE_MUL_EN
  state_t          state;
  logic            is_mul, mul_start, mul_done;
  logic [XLEN-1:0] mul_prod, pc_q, imm_q, busa_q;
  logic [2:0]      br_q;

  assign is_mul    = (alu_op == OP_MUL);
  assign mul_start = accept && is_mul;
  assign load_alu  = accept && !is_mul;
  assign idle      = (state == ST_IDLE);

  exu_mul_iter #(
    .XLEN     (XLEN),
    .MUL_STEP (MUL_STEP)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .abort   (flush),
    .start   (mul_start),
    .opa     (srca),
    .opb     (srcb),
    .done    (mul_done),
    .product (mul_prod)
  );
`else
  assign idle     = 1'b1;
  assign load_alu = accept;
`endif

  assign in_ready = idle && (!out_valid || out_ready) && !flush;
  assign accept   = in_valid && in_ready;

  // controller and result register; flush beats both issue and completion
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_res     <= '0;
      out_dnpc    <= '0;
      out_illegal <= 1'b0;
`ifdef EXU_PIPE_MUL_EN
      state  <= ST_IDLE;
      br_q   <= '0;
      pc_q   <= '0;
      imm_q  <= '0;
      busa_q <= '0;
`endif
    end else if (flush) begin
      out_valid <= 1'b0;
`ifdef EXU_PIPE_MUL_EN
      state <= ST_IDLE;
`endif
    end else begin
      if (load_alu) begin
        out_valid   <= 1'b1;
        out_res     <= alu_res;
        out_dnpc    <= next_pc(branch, pc, imm, busa, alu_res);
        out_illegal <= alu_ill;
      end
`ifdef EXU_PIPE_MUL_EN
      else if (mul_done) begin
        out_valid   <= 1'b1;
        out_res     <= mul_prod;
        out_dnpc    <= next_pc(br_q, pc_q, imm_q, busa_q, mul_prod);
        out_illegal <= 1'b0;
        state       <= ST_IDLE;
      end
`endif
      else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
`ifdef EXU_PIPE_MUL_EN
      if (mul_start) begin
        state  <= ST_MUL;
        br_q   <= branch;
        pc_q   <= pc;
        imm_q  <= imm;
        busa_q <= busa;
      end
`endif
    end
  end

endmodule

// File: tb/tb_exu_pipe.sv
// Self-checking bench for exu_pipe (XLEN=64, MUL_STEP=1). Works for both
// builds: with and without EXU_PIPE_MUL_EN.
module tb_exu_pipe;

`ifdef EXU_PIPE_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif
  localparam int MUL_CYC = 64;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, out_illegal, flush;
  logic [63:0] srca, srcb, pc, imm, busa, out_res, out_dnpc;
  logic [3:0]  alu_op;
  logic [2:0]  branch;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  // model state
  bit          m_valid = 1'b0;
  logic [63:0] m_res = '0, m_dnpc = '0;
  bit          m_ill = 1'b0;
  int          m_busy = 0;
  logic [63:0] p_res, p_dnpc;

  always #5 clk = ~clk;

  exu_pipe #(.XLEN(64), .MUL_STEP(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .srca(srca), .srcb(srcb), .alu_op(alu_op), .branch(branch),
    .pc(pc), .imm(imm), .busa(busa),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_dnpc(out_dnpc), .out_illegal(out_illegal),
    .flush(flush)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] exp_res(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      4'd3: return (a < b) ? 64'd1 : 64'd0;
      4'd4: return a & b;
      4'd5: return a | b;
      4'd6: return a ^ b;
      4'd8: return MUL_EN ? a * b : 64'd0;
      default: return 64'd0;
    endcase
  endfunction

  function automatic bit exp_ill(input logic [3:0] op);
    return !((op <= 4'd6) || (op == 4'd8 && MUL_EN));
  endfunction

  function automatic logic [63:0] exp_dnpc(input logic [2:0] br, input logic [63:0] pcv,
                                           input logic [63:0] immv, input logic [63:0] busav,
                                           input logic [63:0] r);
    logic [63:0] d, tgt, seq;
    bit zero, lt;
    zero = (r == 64'd0);
    lt   = r[0];
    tgt  = pcv + immv;
    seq  = pcv + 64'd4;
    case (br)
      3'b001: d = tgt;
      3'b010: d = busav + immv;
      3'b100: d = zero ? tgt : seq;
      3'b101: d = !zero ? tgt : seq;
      3'b110: d = lt ? tgt : seq;
      3'b111: d = (zero || !lt) ? tgt : seq;
      default: d = seq;
    endcase
    d[0] = 1'b0;
    return d;
  endfunction

  function automatic bit model_ready();
    return (m_busy == 0) && (!m_valid || out_ready) && !flush;
  endfunction

  // cycle model, advanced on every rising edge
  initial forever begin
    bit rdy, acc, done, mul_op;
    @(posedge clk);
    rdy    = model_ready();
    mul_op = (alu_op == 4'd8) && MUL_EN;
    if (rst) begin
      m_valid = 0; m_res = '0; m_dnpc = '0; m_ill = 0; m_busy = 0;
    end else if (flush) begin
      m_valid = 0; m_busy = 0;
    end else begin
      acc  = in_valid && rdy;
      done = 1'b0;
      if (m_busy > 0) begin
        m_busy--;
        done = (m_busy == 0);
      end
      if (acc && !mul_op) begin
        m_valid = 1;
        m_res   = exp_res(alu_op, srca, srcb);
        m_dnpc  = exp_dnpc(branch, pc, imm, busa, m_res);
        m_ill   = exp_ill(alu_op);
      end else if (done) begin
        m_valid = 1; m_res = p_res; m_dnpc = p_dnpc; m_ill = 0;
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
      if (acc && mul_op) begin
        m_busy = MUL_CYC;
        p_res  = srca * srcb;
        p_dnpc = exp_dnpc(branch, pc, imm, busa, p_res);
      end
    end
  end

  // per-cycle compare against the model
  initial forever begin
    @(negedge clk);
    if (cmp_on) begin
      check("model_out_valid", out_valid, m_valid);
      check("model_in_ready", in_ready, model_ready());
      if (m_valid) begin
        check("model_out_res", out_res, m_res);
        check("model_out_dnpc", out_dnpc, m_dnpc);
        check("model_out_illegal", out_illegal, m_ill);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [2:0] br, input logic [63:0] pcv, input logic [63:0] immv,
                       input logic [63:0] busav);
    alu_op = op; srca = a; srcb = b; branch = br; pc = pcv; imm = immv; busa = busav;
    in_valid = 1'b1;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [63:0] a, b;
    logic [2:0]  br;
    logic [63:0] pcv, immv, busav, res, dnpc;
    logic        ill;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int cnt;
    logic [63:0] mul_exp;
    vecs[0]  = '{4'd0, 64'd5, 64'd7, 3'b000, 64'h1000, 64'h0, 64'h0, 64'd12, 64'h1004, 1'b0};
    vecs[1]  = '{4'd1, 64'd9, 64'd9, 3'b100, 64'h80, 64'h20, 64'h0, 64'd0, 64'hA0, 1'b0};
    vecs[2]  = '{4'd1, 64'd9, 64'd9, 3'b101, 64'h80, 64'h20, 64'h0, 64'd0, 64'h84, 1'b0};
    vecs[3]  = '{4'd0, 64'd0, 64'd0, 3'b010, 64'h0, 64'h10, 64'h2001, 64'd0, 64'h2010, 1'b0};
    vecs[4]  = '{4'd2, '1, 64'd1, 3'b110, 64'h100, 64'h40, 64'h0, 64'd1, 64'h140, 1'b0};
    vecs[5]  = '{4'd3, '1, 64'd1, 3'b110, 64'h100, 64'h40, 64'h0, 64'd0, 64'h104, 1'b0};
    vecs[6]  = '{4'd4, 64'hF0F0, 64'hFF00, 3'b111, 64'h200, 64'h8, 64'h0, 64'hF000, 64'h208, 1'b0};
    vecs[7]  = '{4'd5, 64'd1, 64'd2, 3'b111, 64'h200, 64'h8, 64'h0, 64'd3, 64'h204, 1'b0};
    vecs[8]  = '{4'd6, 64'd5, 64'd5, 3'b101, 64'h300, 64'h10, 64'h0, 64'd0, 64'h304, 1'b0};
    vecs[9]  = '{4'd0, 64'd1, 64'd1, 3'b001, 64'h400, 64'h11, 64'h0, 64'd2, 64'h410, 1'b0};
    vecs[10] = '{4'd0, '1, 64'd2, 3'b000, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h0, 64'd1, 64'h0, 1'b0};
    vecs[11] = '{4'd7, 64'd3, 64'd4, 3'b100, 64'h500, 64'h10, 64'h0, 64'd0, 64'h510, 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    srca = '0; srcb = '0; alu_op = '0; branch = '0; pc = '0; imm = '0; busa = '0;
    tick();
    cmp_on = 1'b1;
    tick();
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_res", out_res, 0);
    check("rst_out_dnpc", out_dnpc, 0);
    check("rst_out_illegal", out_illegal, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);

    // directed single-op vectors
    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].br, vecs[i].pcv, vecs[i].immv, vecs[i].busav);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), out_valid, 1);
      check($sformatf("vec%0d_res", i), out_res, vecs[i].res);
      check($sformatf("vec%0d_dnpc", i), out_dnpc, vecs[i].dnpc);
      check($sformatf("vec%0d_illegal", i), out_illegal, vecs[i].ill);
    end

    // multiply: all-ones * 3
    drive(4'd8, '1, 64'd3, 3'b000, 64'h700, 64'h0, 64'h0);
    tick();
    in_valid = 1'b0;
    cnt = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (out_valid) break;
      if (!in_ready) cnt++;
    end
    check("mul_out_valid", out_valid, 1);
`ifdef EXU_PIPE_MUL_EN
    mul_exp = 64'hFFFF_FFFF_FFFF_FFFD;
    check("mul_busy_cycles", cnt, MUL_CYC);
    check("mul_res", out_res, mul_exp);
    check("mul_illegal", out_illegal, 0);
`else
    mul_exp = 64'h0;
    check("mul_busy_cycles", cnt, 0);
    check("mul_res", out_res, mul_exp);
    check("mul_illegal", out_illegal, 1);
`endif
    check("mul_dnpc", out_dnpc, 64'h704);
    tick();

    // stall with result pending, then four back-to-back ADDs
    out_ready = 1'b0;
    drive(4'd0, 64'h11, 64'h22, 3'b000, 64'h40, 64'h0, 64'h0);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_res", out_res, 64'h33);
      check("stall_dnpc", out_dnpc, 64'h44);
      check("stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(4'd0, 64'(k), 64'd100, 3'b000, 64'h600, 64'h0, 64'h0);
      tick();
      @(negedge clk);
      check("b2b_valid", out_valid, 1);
      check("b2b_res", out_res, 64'(100 + k));
    end
    in_valid = 1'b0;
    tick();
    @(negedge clk);
    check("b2b_drain", out_valid, 0);

    // flush during a multiply
    drive(4'd8, 64'd7, 64'd6, 3'b000, 64'h800, 64'h0, 64'h0);
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    cnt = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("flush_no_result", cnt, 0);

    // reset during a multiply
    drive(4'd8, 64'd7, 64'd6, 3'b000, 64'h900, 64'h0, 64'h0);
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rstmul_out_valid", out_valid, 0);
    check("rstmul_in_ready", in_ready, 1);
    cnt = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("rstmul_no_result", cnt, 0);

    // pipe still works after abort
    drive(4'd0, 64'd2, 64'd3, 3'b000, 64'hA00, 64'h0, 64'h0);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("post_res", out_res, 64'd5);
    check("post_dnpc", out_dnpc, 64'hA04);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
